// File: rtl/alu_ctrl_sequencer.sv
// Registered ALU control decoder that sequences multi-cycle MUL/DIV ops.
// It pulses mul_start on launch and stalls upstream until the result is due.
module alu_ctrl_sequencer #(
    parameter int unsigned FUNCT_W    = 4,
    parameter int unsigned CTRL_W     = 4,
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [1:0]         ALUop,
    input  logic [FUNCT_W-1:0] functCode,
    output logic [CTRL_W-1:0]  ctrlOut,
    output logic               out_valid,
    output logic               mul_start,
    output logic               stall,
    output logic               illegal
);

    localparam int unsigned MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e            r_state;
    logic [CNT_W-1:0]  r_count;
    logic [CTRL_W-1:0] r_ctrl;
    logic              r_out_valid;
    logic              r_mul_start;
    logic              r_stall;
    logic              r_illegal;

    logic [CTRL_W-1:0] w_code;
    logic              w_multi;
    logic              w_illegal;
    logic [CNT_W-1:0]  w_count_init;
    logic              w_accept;

    always_comb begin
        w_code       = '0;
        w_multi      = 1'b0;
        w_illegal    = 1'b0;
        w_count_init = '0;
        unique case (ALUop)
            2'b00: w_code = CTRL_W'(4'b1100);
            2'b10: w_code = CTRL_W'(4'b1110);
            2'b11: w_code = CTRL_W'(4'b1111);
            2'b01: begin
                if (functCode == FUNCT_W'(4'b0001)) begin
                    w_code = CTRL_W'(4'b0001);
                end else if (functCode == FUNCT_W'(4'b0010)) begin
                    w_code = CTRL_W'(4'b0010);
                end else if (functCode == FUNCT_W'(4'b0100)) begin
                    w_code       = CTRL_W'(4'b0100);
                    w_multi      = 1'b1;
                    w_count_init = CNT_W'(MUL_CYCLES - 1);
                end else if (functCode == FUNCT_W'(4'b1000)) begin
                    w_code       = CTRL_W'(4'b1000);
                    w_multi      = 1'b1;
                    w_count_init = CNT_W'(DIV_CYCLES - 1);
                end else begin
                    w_illegal = 1'b1;
                end
            end
            default: w_code = '0;
        endcase
    end

    assign w_accept = in_valid && !r_stall;

    // Counter reaching zero retires to idle, so the result cycle can accept a new op.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_count     <= '0;
            r_ctrl      <= '0;
            r_out_valid <= 1'b0;
            r_mul_start <= 1'b0;
            r_stall     <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (flush) begin
            r_state     <= StIdle;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_mul_start <= 1'b0;
            r_stall     <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_mul_start <= 1'b0;
            r_illegal   <= 1'b0;
            unique case (r_state)
                StBusy: begin
                    if (r_count == CNT_W'(1)) begin
                        r_state     <= StIdle;
                        r_count     <= '0;
                        r_stall     <= 1'b0;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_count <= r_count - CNT_W'(1);
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_ctrl <= w_code;
                        if (w_multi) begin
                            r_state     <= StBusy;
                            r_count     <= w_count_init;
                            r_stall     <= 1'b1;
                            r_mul_start <= 1'b1;
                        end else begin
                            r_out_valid <= 1'b1;
                            r_illegal   <= w_illegal;
                        end
                    end
                end
            endcase
        end
    end

    assign ctrlOut   = r_ctrl;
    assign out_valid = r_out_valid;
    assign mul_start = r_mul_start;
    assign stall     = r_stall;
    assign illegal   = r_illegal;

endmodule

// File: doc/alu_ctrl_sequencer.md
Name: alu_ctrl_sequencer

Overview:
Registered, multi-cycle successor to the combinational ALU control decoder. It decodes ALUop/functCode into the ALU control word and sequences multi-cycle MUL and DIV operations with a per-op latency counter. It drives a start pulse to the iterative MUL/DIV datapath and stalls the upstream pipeline until the result is due. It sits between the ID/EX pipeline register and the ALU/multiplier-divider unit.

Parameters:
FUNCT_W, 4, functCode width; one-hot codes occupy bits [3:0], any upper bits must be 0 for a legal code
CTRL_W, 4, ctrlOut width (≥4); codes below are zero-extended into it
MUL_CYCLES, 4, total MUL latency in cycles from acceptance to out_valid (≥2)
DIV_CYCLES, 8, total DIV latency in cycles from acceptance to out_valid (≥2)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  synchronous abort of any in-flight op (branch/hazard flush)
in_valid  in  1  ALUop/functCode valid this cycle
ALUop  in  2  operation class
functCode  in  FUNCT_W  function field, one-hot
ctrlOut  out  CTRL_W  registered ALU control word
out_valid  out  1  one-cycle pulse: ctrlOut result due this cycle
mul_start  out  1  one-cycle pulse launching the MUL/DIV iterative unit
stall  out  1  upstream must hold; in_valid ignored while high
illegal  out  1  registered, set with out_valid for an undefined functCode

Behaviour:
- Reset (rst=1 at edge): state IDLE, counter 0; ctrlOut=0, out_valid=0, mul_start=0, stall=0, illegal=0. rst has priority over flush and in_valid.
- Accept: in_valid=1 and stall=0 at an edge. Decoding at acceptance:
  ALUop 00 -> 1100; 10 -> 1110; 11 -> 1111; 01 -> functCode 0001->0001 ADD, 0010->0010 SUB, 0100->0100 MUL, 1000->1000 DIV.
  Any other functCode with ALUop 01 -> ctrlOut 0000, illegal=1, treated as single-cycle.
  No input combination leaves ctrlOut undefined or holding a stale value.
- Single-cycle op accepted at edge N: ctrlOut updated, out_valid=1 (and illegal, if applicable) during cycle N+1. Latency 1. Back-to-back acceptance every cycle is allowed.
- MUL/DIV accepted at edge N (LAT = MUL_CYCLES or DIV_CYCLES):
  - Enter BUSY with counter = LAT-1 and ctrlOut updated. Cycle N+1: mul_start=1.
  - Counter decrements each cycle. stall=1 while counter≠0, i.e. cycles N+1..N+LAT-1.
  - Cycle N+LAT (counter=0): out_valid=1, stall=0. A new op may be accepted at the closing edge of that cycle (zero bubble). Otherwise return to IDLE.
- ctrlOut holds its last value between ops. out_valid and mul_start are strictly single-cycle pulses.
- flush=1 at edge: state IDLE, counter 0, stall=0. No out_valid or mul_start is produced for the aborted op. in_valid in that same cycle is dropped. ctrlOut retains its last value.
- rst or flush during BUSY takes effect at that edge; stall is low the following cycle.
- in_valid while stall=1 is ignored, with no side effects.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> all outputs 0; first accepted op after release behaves normally.
- Single-cycle stream: ALUop=01, functCode 0001, 0010 on consecutive cycles, then ALUop=00, 10, 11 -> ctrlOut 0001, 0010, 1100, 1110, 1111 on consecutive cycles, out_valid=1 each cycle, stall=0.
- MUL at defaults: accept 01/0100 at edge N -> mul_start in N+1, stall high N+1..N+3, out_valid and ctrlOut=0100 in N+4. An ADD offered at N+2 is ignored. An ADD presented in N+4 gives out_valid with 0001 in N+5.
- DIV, then flush at N+3 -> stall low from N+4, no out_valid or mul_start afterwards. The next SUB completes in 1 cycle.
- Illegal: ALUop=01, functCode 0011 -> ctrlOut 0000, illegal=1, out_valid=1 one cycle later; illegal=0 on the next legal op.
- Parameter sweep: MUL_CYCLES=2, DIV_CYCLES=16, CTRL_W=6 -> stall spans 1 and 15 cycles respectively; ctrlOut upper bits always 0.
